pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Controls the PLL primitive's reset and consumes its LOCK output, on the other side of the PLL reset/lock interface.
- Runs on the HSOSC reference clock, the same clock that feeds the PLL. It is the only clock the block uses.
- Sequence: holds the PLL in reset, waits for lock with a timeout and bounded retries, and requires lock to stay high for a debounce window. Only then does it release a fabric reset and assert ready.
- On lock loss it re-sequences. After exhausted retries it latches a fault.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst_n is held low per PLL reset attempt (min 1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt fails (min 2).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock-high cycles required before release (min 1).
- SYNC_STAGES, 2: flops in the pll_locked synchronizer (min 2).
- MAX_RETRIES, 3: PLL re-reset attempts after the first failed attempt before FAULT.

Ports:
- clk  input  1  HSOSC reference clock (same clock as PLL REFERENCECLK).
- rst_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL LOCK; asynchronous to clk.
- pll_rst_n  output  1  drives the PLL RESET_N; registered.
- sys_rst_n  output  1  fabric reset request, active-low; registered. The consumer re-synchronizes it into the PLL clock domain.
- ready  output  1  high only in RUN; registered.
- fault  output  1  high only in FAULT; registered.
- retry_cnt  output  $clog2(MAX_RETRIES+1)  failed attempts since the last RUN entry or reset.

Behaviour:
- Reset (rst_n low, async): state=PLL_RESET, counter=0, retry_cnt=0, sync flops=0, pll_rst_n=0, sys_rst_n=0, ready=0, fault=0.
- lock_s is pll_locked after SYNC_STAGES flops. All FSM decisions use lock_s only.
- Outputs are Moore-decoded from state and registered. They change on the clock edge the state changes.
- Single counter, cleared on every state transition. Width covers max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES).
- PLL_RESET:
  - Outputs: pll_rst_n=0, sys_rst_n=0.
  - When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - pll_rst_n is therefore low for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - Outputs: pll_rst_n=1, sys_rst_n=0.
  - If lock_s=1, go to STABILIZE. This takes priority over timeout when both occur in the same cycle.
  - Else if counter==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAULT;
    - else retry_cnt+=1 and go to PLL_RESET.
- STABILIZE:
  - Outputs: pll_rst_n=1, sys_rst_n=0.
  - If lock_s=0, go to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
  - Else if counter==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN:
  - Outputs: pll_rst_n=1, sys_rst_n=1, ready=1.
  - retry_cnt is cleared on entry.
  - If lock_s=0, go to PLL_RESET. sys_rst_n and ready drop on that edge. retry_cnt stays 0, since a lock loss is not a failed attempt.
- FAULT:
  - Outputs: pll_rst_n=0, sys_rst_n=0, ready=0, fault=1.
  - Terminal state. Exit only via rst_n.
- Release timing: if lock is stable from synchronizer input edge E, ready rises at edge E+SYNC_STAGES+LOCK_STABLE_CYCLES.
- Glitches: a lock_s glitch shorter than LOCK_STABLE_CYCLES during STABILIZE never releases sys_rst_n.
- Reset mid-operation: asserting rst_n in any state immediately returns all outputs to reset values without waiting for a clock.
- retry_cnt saturates at MAX_RETRIES and never wraps.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2, MAX_RETRIES=2):
1. Nominal lock:
   - Stimulus: release rst_n; pll_locked=1 ten cycles after pll_rst_n rises.
   - Required: pll_rst_n low exactly 4 cycles. ready and sys_rst_n rise exactly 10 edges after the lock edge. retry_cnt=0, fault=0.
2. Glitchy lock:
   - Stimulus: in STABILIZE, pulse pll_locked high 5 cycles, low 3 cycles, then high permanently.
   - Required: no ready during the pulse. ready rises 10 edges after the final rising edge.
3. Timeout retry:
   - Stimulus: hold pll_locked=0 for one 32-cycle window, then assert it during the second attempt.
   - Required: retry_cnt=1, a second 4-cycle pll_rst_n low pulse, then RUN. retry_cnt=0 once ready is high.
4. Fault:
   - Stimulus: pll_locked stuck 0.
   - Required: three WAIT_LOCK windows with retry_cnt 0→1→2, then fault=1. pll_rst_n held 0 and ready=0 forever. Later raising pll_locked has no effect.
5. Lock loss in RUN:
   - Stimulus: drop pll_locked for 1 cycle.
   - Required: ready and sys_rst_n drop 3 edges later, a new 4-cycle pll_rst_n pulse follows, and retry_cnt stays 0.
6. Async reset:
   - Stimulus: assert rst_n mid-STABILIZE, between clock edges.
   - Required: all outputs return to reset values immediately, before the next clk edge. The sequence restarts from PLL_RESET on release.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// PLL reset/lock handshake plus the fabric-facing status of the reset sequencer.
// The sequencer side (master) drives the PLL reset and the status outputs and
// consumes the PLL lock indication; the slave side is the PLL and fabric view.
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic               pll_locked;
  logic               pll_rst_n;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  pll_locked,
    output pll_rst_n,
    output sys_rst_n,
    output ready,
    output fault,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst_n,
    input  sys_rst_n,
    input  ready,
    input  fault,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer running on the HSOSC reference clock.
// Holds the PLL in reset, waits for lock with a timeout and bounded retries,
// demands a stable lock window, then releases the fabric reset and raises ready.
// Lock loss in RUN re-sequences; exhausting the retries latches a fault.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int SYNC_STAGES        = 2,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  // One counter serves every timed state, so it is sized for the longest one.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  localparam logic [2:0] ST_PLL_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABILIZE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lockS;

  logic [2:0]         state_q,    state_d;
  logic [CNT_W-1:0]   counter_q,  counter_d;
  logic [RETRY_W-1:0] retryCnt_q, retryCnt_d;

  logic pllRstN_q;
  logic sysRstN_q;
  logic ready_q;
  logic fault_q;

  // Bring the asynchronous PLL lock into the clk domain; only lockS is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign lockS = sync_q[SYNC_STAGES-1];

  // Next-state logic: decide transitions, advance the shared counter and track failed attempts.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q + 1'b1;
    retryCnt_d = retryCnt_q;

    case (state_q)
      ST_PLL_RESET: begin
        if (counter_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins over the timeout.
        if (lockS) begin
          state_d = ST_STABILIZE;
        end else if (counter_q == TIMEOUT_LAST) begin
          if (retryCnt_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retryCnt_d = retryCnt_q + 1'b1;
            state_d    = ST_PLL_RESET;
          end
        end
      end

      ST_STABILIZE: begin
        // Losing lock here is not a failed attempt; the timeout simply restarts.
        if (!lockS) begin
          state_d = ST_WAIT_LOCK;
        end else if (counter_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        counter_d = counter_q;
        if (!lockS) begin
          state_d = ST_PLL_RESET;
        end
      end

      ST_FAULT: begin
        counter_d = counter_q;
      end

      default: begin
        state_d = ST_PLL_RESET;
      end
    endcase

    // Every state change restarts the timing of the new state.
    if (state_d != state_q) begin
      counter_d = '0;
    end

    // A successful release forgets earlier failed attempts.
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      retryCnt_d = '0;
    end
  end

  // Sequencer state, counter and retry count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PLL_RESET;
      counter_q  <= '0;
      retryCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      retryCnt_q <= retryCnt_d;
    end
  end

  // Registered Moore outputs decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pllRstN_q <= 1'b0;
      sysRstN_q <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pllRstN_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE) || (state_d == ST_RUN);
      sysRstN_q <= (state_d == ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_rst_n = pllRstN_q;
  assign bus.sys_rst_n = sysRstN_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retryCnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios with literal timing
// expectations, followed by randomized lock behaviour and resets, all checked
// every cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES     = 4;
  localparam int LOCK_TIMEOUT       = 32;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int SYNC_STAGES        = 2;
  localparam int MAX_RETRIES        = 2;

  localparam int PH_HOLD  = 0;
  localparam int PH_SEEK  = 1;
  localparam int PH_SETTL = 2;
  localparam int PH_LIVE  = 3;
  localparam int PH_DEAD  = 4;

  localparam int SEL_PLLRST = 0;
  localparam int SEL_READY  = 1;
  localparam int SEL_FAULT  = 2;
  localparam int SEL_SYSRST = 3;
  localparam int SEL_RETRY  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   edgeCnt;

  int   mPhase;
  int   mElapsed;
  int   mRetries;
  bit   mHist[$];

  pll_reset_sequencer_if #(.MAX_RETRIES(MAX_RETRIES)) bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (PLL_RST_CYCLES),
    .LOCK_TIMEOUT      (LOCK_TIMEOUT),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .SYNC_STAGES       (SYNC_STAGES),
    .MAX_RETRIES       (MAX_RETRIES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running reference clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] readOut(input int which);
    case (which)
      SEL_PLLRST: return 32'(bus.pll_rst_n);
      SEL_READY:  return 32'(bus.ready);
      SEL_FAULT:  return 32'(bus.fault);
      SEL_SYSRST: return 32'(bus.sys_rst_n);
      default:    return 32'(bus.retry_cnt);
    endcase
  endfunction

  // Bounded wait, sampled on falling edges; an expired bound counts as a failure.
  task automatic waitOut(input int which, input int val, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (readOut(which) == 32'(val)) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out after %0d cycles, wanted %0d", name, limit, val);
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    bus.pll_locked = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic modelReset();
    mPhase   = PH_HOLD;
    mElapsed = 0;
    mRetries = 0;
    mHist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) mHist.push_back(1'b0);
  endtask

  task automatic modelEnter(input int ph);
    mPhase   = ph;
    mElapsed = 0;
  endtask

  // One clock of the reference model: the sequencer sees lock as it was SYNC_STAGES samples ago.
  task automatic modelStep(input bit sample);
    bit seen;
    seen = mHist[SYNC_STAGES-1];
    mHist.push_front(sample);
    void'(mHist.pop_back());
    mElapsed++;
    case (mPhase)
      PH_HOLD:  if (mElapsed >= PLL_RST_CYCLES) modelEnter(PH_SEEK);
      PH_SEEK: begin
        if (seen) modelEnter(PH_SETTL);
        else if (mElapsed >= LOCK_TIMEOUT) begin
          if (mRetries >= MAX_RETRIES) modelEnter(PH_DEAD);
          else begin
            mRetries++;
            modelEnter(PH_HOLD);
          end
        end
      end
      PH_SETTL: begin
        if (!seen) modelEnter(PH_SEEK);
        else if (mElapsed >= LOCK_STABLE_CYCLES) begin
          mRetries = 0;
          modelEnter(PH_LIVE);
        end
      end
      PH_LIVE:  if (!seen) modelEnter(PH_HOLD);
      default: ;
    endcase
  endtask

  // Compare process: advance the model on every edge or async reset, then check all outputs.
  initial begin
    modelReset();
    edgeCnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        modelReset();
        edgeCnt = 0;
      end else begin
        modelStep(bus.pll_locked);
        edgeCnt++;
      end
      #1;
      checkOutput("pll_rst_n", 32'(bus.pll_rst_n), 32'((mPhase == PH_SEEK) || (mPhase == PH_SETTL) || (mPhase == PH_LIVE)));
      checkOutput("sys_rst_n", 32'(bus.sys_rst_n), 32'(mPhase == PH_LIVE));
      checkOutput("ready",     32'(bus.ready),     32'(mPhase == PH_LIVE));
      checkOutput("fault",     32'(bus.fault),     32'(mPhase == PH_DEAD));
      checkOutput("retry_cnt", 32'(bus.retry_cnt), 32'(mRetries));
    end
  end

  // Directed scenarios with literal expectations, then randomized lock behaviour.
  initial begin
    int lockEdge;
    int refEdge;
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Nominal lock.
    waitOut(SEL_PLLRST, 1, 50, "t1 pll_rst_n rise");
    checkOutput("t1 pll_rst_n low cycles", 32'(edgeCnt), 32'd4);
    applyStimulus(1'b0, 10);
    bus.pll_locked = 1'b1;
    lockEdge = edgeCnt + 1;
    waitOut(SEL_READY, 1, 50, "t1 ready rise");
    checkOutput("t1 ready latency", 32'(edgeCnt - lockEdge), 32'd10);
    checkOutput("t1 sys_rst_n", 32'(bus.sys_rst_n), 32'd1);
    checkOutput("t1 retry_cnt", 32'(bus.retry_cnt), 32'd0);
    checkOutput("t1 fault", 32'(bus.fault), 32'd0);

    // Lock loss in RUN.
    applyStimulus(1'b1, 5);
    refEdge = edgeCnt;
    applyStimulus(1'b0, 1);
    bus.pll_locked = 1'b1;
    waitOut(SEL_READY, 0, 20, "t5 ready drop");
    checkOutput("t5 ready drop delay", 32'(edgeCnt - refEdge), 32'd3);
    checkOutput("t5 sys_rst_n drop", 32'(bus.sys_rst_n), 32'd0);
    checkOutput("t5 pll_rst_n low", 32'(bus.pll_rst_n), 32'd0);
    refEdge = edgeCnt;
    waitOut(SEL_PLLRST, 1, 20, "t5 pll_rst_n rise");
    checkOutput("t5 pll_rst_n pulse", 32'(edgeCnt - refEdge), 32'd4);
    checkOutput("t5 retry_cnt", 32'(bus.retry_cnt), 32'd0);
    waitOut(SEL_READY, 1, 50, "t5 ready again");
    checkOutput("t5 retry_cnt after", 32'(bus.retry_cnt), 32'd0);

    // Glitchy lock.
    doReset();
    bus.pll_locked = 1'b0;
    waitOut(SEL_PLLRST, 1, 50, "t2 pll_rst_n rise");
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 5);
    checkOutput("t2 no ready during pulse", 32'(bus.ready), 32'd0);
    applyStimulus(1'b0, 3);
    checkOutput("t2 no ready after pulse", 32'(bus.ready), 32'd0);
    bus.pll_locked = 1'b1;
    lockEdge = edgeCnt + 1;
    waitOut(SEL_READY, 1, 50, "t2 ready rise");
    checkOutput("t2 ready latency", 32'(edgeCnt - lockEdge), 32'd10);

    // Timeout retry.
    doReset();
    bus.pll_locked = 1'b0;
    waitOut(SEL_RETRY, 1, 100, "t3 retry step");
    checkOutput("t3 retry edge", 32'(edgeCnt), 32'd36);
    checkOutput("t3 pll_rst_n relow", 32'(bus.pll_rst_n), 32'd0);
    waitOut(SEL_PLLRST, 1, 20, "t3 second rise");
    checkOutput("t3 second pulse end", 32'(edgeCnt), 32'd40);
    bus.pll_locked = 1'b1;
    checkOutput("t3 retry_cnt one", 32'(bus.retry_cnt), 32'd1);
    waitOut(SEL_READY, 1, 50, "t3 ready rise");
    checkOutput("t3 retry cleared", 32'(bus.retry_cnt), 32'd0);

    // Fault after exhausted retries.
    doReset();
    bus.pll_locked = 1'b0;
    waitOut(SEL_FAULT, 1, 300, "t4 fault rise");
    checkOutput("t4 fault edge", 32'(edgeCnt), 32'd108);
    checkOutput("t4 retry_cnt", 32'(bus.retry_cnt), 32'd2);
    applyStimulus(1'b1, 60);
    checkOutput("t4 fault held", 32'(bus.fault), 32'd1);
    checkOutput("t4 ready low", 32'(bus.ready), 32'd0);
    checkOutput("t4 pll_rst_n low", 32'(bus.pll_rst_n), 32'd0);
    checkOutput("t4 sys_rst_n low", 32'(bus.sys_rst_n), 32'd0);

    // Async reset mid-STABILIZE.
    doReset();
    bus.pll_locked = 1'b1;
    waitOut(SEL_PLLRST, 1, 50, "t6 pll_rst_n rise");
    applyStimulus(1'b1, 4);
    checkOutput("t6 pre pll_rst_n", 32'(bus.pll_rst_n), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async pll_rst_n", 32'(bus.pll_rst_n), 32'd0);
    checkOutput("t6 async sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    checkOutput("t6 async ready", 32'(bus.ready), 32'd0);
    checkOutput("t6 async fault", 32'(bus.fault), 32'd0);
    checkOutput("t6 async retry", 32'(bus.retry_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitOut(SEL_PLLRST, 1, 50, "t6 restart rise");
    checkOutput("t6 restart pulse", 32'(edgeCnt), 32'd4);

    // Randomized lock behaviour with occasional resets.
    for (int it = 0; it < 400; it++) begin
      int r;
      logic lvl;
      int len;
      r   = $urandom_range(0, 99);
      lvl = ($urandom_range(0, 99) < 75);
      if (r < 3) begin
        doReset();
      end else begin
        if (lvl) len = $urandom_range(1, 80);
        else if (r < 15) len = $urandom_range(30, 150);
        else len = $urandom_range(1, 12);
        applyStimulus(lvl, len);
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
